// File: rtl/dbu_pipeline_pkg.sv
// Shared constants for the debug unit.
// Probe address masks, strides and display selector codes.
package dbu_pipeline_pkg;

    localparam logic [15:0] RF_ADDR_MASK  = 16'h001F;
    localparam logic [15:0] MEM_ADDR_MASK = 16'h03FC;
    localparam logic [15:0] RF_STRIDE     = 16'd1;
    localparam logic [15:0] MEM_STRIDE    = 16'd4;
    localparam logic [2:0]  SEL_PROBE     = 3'd0;

endpackage

// File: rtl/dbu_pipeline_btn.sv
// Button conditioner: 2-flop sync, debounce counter,
// one-cycle pulse on each accepted press.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          deb_q, deb_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count while the level disagrees; flip once it has held long enough.
    always_comb begin
        cnt_d   = '0;
        deb_d   = deb_q;
        pulse_d = 1'b0;
        if (s2_q != deb_q) begin
            if (cnt_q == CNT_MAX) begin
                deb_d   = s2_q;
                pulse_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer, debounce state and pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            deb_q   <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= btn_i;
            s2_q    <= s1_q;
            deb_q   <= deb_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/dbu_pipeline.sv
// Debug unit: run/step control, probe address,
// selector forwarding and display routing.
module dbu_pipeline
    import dbu_pipeline_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ADDR_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              succ,
    input  logic              step,
    input  logic              inc,
    input  logic              dec,
    input  logic              m_rf,
    input  logic [2:0]        sel,
    input  logic [1:0]        sub_sel,
    input  logic [15:0]       status,
    input  logic [31:0]       m_data,
    input  logic [31:0]       rf_data,
    input  logic [31:0]       o_sel_data,
    output logic              cpu_en,
    output logic [ADDR_W-1:0] m_rf_addr,
    output logic [2:0]        i_sel0,
    output logic [1:0]        i_sel1,
    output logic [15:0]       led,
    output logic [31:0]       seg_data
);

    logic              step_p, inc_p, dec_p;
    logic              succ_s1_q, succ_s2_q;
    logic              mrf_s1_q, mrf_s2_q, mrf_s3_q;
    logic              cpu_en_q, cpu_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] mask, stride;
    logic [2:0]        sel0_q;
    logic [1:0]        sel1_q;
    logic [15:0]       led_q, led_d;
    logic [31:0]       seg_q, seg_d;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
        .clk(clk), .rst(rst), .btn_i(step), .pulse_o(step_p)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clk(clk), .rst(rst), .btn_i(inc), .pulse_o(inc_p)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
        .clk(clk), .rst(rst), .btn_i(dec), .pulse_o(dec_p)
    );

    // Next-state for run control, probe address and display.
    always_comb begin
        cpu_en_d = succ_s2_q | step_p;
        mask     = mrf_s2_q ? ADDR_W'(MEM_ADDR_MASK) : ADDR_W'(RF_ADDR_MASK);
        stride   = mrf_s2_q ? ADDR_W'(MEM_STRIDE) : ADDR_W'(RF_STRIDE);
        addr_d   = addr_q;
        if (mrf_s2_q != mrf_s3_q) begin
            addr_d = '0;
        end else if (inc_p && !dec_p) begin
            addr_d = (addr_q + stride) & mask;
        end else if (dec_p && !inc_p) begin
            addr_d = (addr_q - stride) & mask;
        end
        if (sel == SEL_PROBE) begin
            seg_d = mrf_s2_q ? m_data : rf_data;
            led_d = {mrf_s2_q, 5'b0, addr_q[9:0]};
        end else begin
            seg_d = o_sel_data;
            led_d = status;
        end
    end

    // Switch synchronizers and all output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            succ_s1_q <= 1'b0;
            succ_s2_q <= 1'b0;
            mrf_s1_q  <= 1'b0;
            mrf_s2_q  <= 1'b0;
            mrf_s3_q  <= 1'b0;
            cpu_en_q  <= 1'b0;
            addr_q    <= '0;
            sel0_q    <= '0;
            sel1_q    <= '0;
            led_q     <= '0;
            seg_q     <= '0;
        end else begin
            succ_s1_q <= succ;
            succ_s2_q <= succ_s1_q;
            mrf_s1_q  <= m_rf;
            mrf_s2_q  <= mrf_s1_q;
            mrf_s3_q  <= mrf_s2_q;
            cpu_en_q  <= cpu_en_d;
            addr_q    <= addr_d;
            sel0_q    <= sel;
            sel1_q    <= sub_sel;
            led_q     <= led_d;
            seg_q     <= seg_d;
        end
    end

    assign cpu_en    = cpu_en_q;
    assign m_rf_addr = addr_q;
    assign i_sel0    = sel0_q;
    assign i_sel1    = sel1_q;
    assign led       = led_q;
    assign seg_data  = seg_q;

endmodule

// File: tb/tb_dbu_pipeline.sv
// Testbench for dbu_pipeline: timed expectations queued by
// stimulus, compared by a negedge monitor.
module tb_dbu_pipeline;

    localparam int K_EN   = 0;
    localparam int K_ADDR = 1;
    localparam int K_SEG  = 2;
    localparam int K_LED  = 3;
    localparam int K_S0   = 4;
    localparam int K_S1   = 5;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        succ = 1'b0;
    logic        step = 1'b0;
    logic        inc = 1'b0;
    logic        dec = 1'b0;
    logic        m_rf = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic [1:0]  sub_sel = 2'd0;
    logic [15:0] status = 16'd0;
    logic [31:0] m_data = 32'd0;
    logic [31:0] rf_data = 32'd0;
    logic [31:0] o_sel_data = 32'd0;
    logic        cpu_en;
    logic [15:0] m_rf_addr;
    logic [2:0]  i_sel0;
    logic [1:0]  i_sel1;
    logic [15:0] led;
    logic [31:0] seg_data;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t exp_q[$];

    int   addr_m = 0;
    bit   mode_m = 1'b0;

    dbu_pipeline #(.DEBOUNCE_CYCLES(4), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .succ(succ), .step(step),
        .inc(inc), .dec(dec), .m_rf(m_rf), .sel(sel),
        .sub_sel(sub_sel), .status(status), .m_data(m_data),
        .rf_data(rf_data), .o_sel_data(o_sel_data),
        .cpu_en(cpu_en), .m_rf_addr(m_rf_addr), .i_sel0(i_sel0),
        .i_sel1(i_sel1), .led(led), .seg_data(seg_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input exp_t e);
        logic [31:0] act;
        string       nm;
        act = '0;
        nm  = "?";
        case (e.kind)
            K_EN:   begin act = {31'b0, cpu_en}; nm = "cpu_en";    end
            K_ADDR: begin act = {16'b0, m_rf_addr}; nm = "m_rf_addr"; end
            K_SEG:  begin act = seg_data; nm = "seg_data";  end
            K_LED:  begin act = {16'b0, led}; nm = "led";       end
            K_S0:   begin act = {29'b0, i_sel0}; nm = "i_sel0";    end
            K_S1:   begin act = {30'b0, i_sel1}; nm = "i_sel1";    end
            default: ;
        endcase
        n_checks++;
        if (act === e.val) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, e.val);
    endtask

    // Monitor: compare every expectation due in this cycle.
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
                check(exp_q[i]);
                exp_q.delete(i);
            end
        end
    end

    task automatic push(input int c, input int kd, input logic [31:0] v);
        exp_t e;
        e.cyc  = c;
        e.kind = kd;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_all_zero(input int c);
        for (int kd = K_EN; kd <= K_S1; kd++) push(c, kd, 32'd0);
    endtask

    function automatic int model_next(input int a, input int which,
                                      input bit mem);
        int d;
        d = (which == 1) ? 1 : (which == 2) ? -1 : 0;
        if (mem) return ((((a / 4) + d) % 256 + 256) % 256) * 4;
        return ((a + d) % 32 + 32) % 32;
    endfunction

    // Step press: a held press gives cpu_en on the 7th edge after
    // step rises; a short glitch gives nothing; run mode keeps it high.
    task automatic do_step(input int hold, input bit run);
        int k;
        bit pulse;
        k     = cyc;
        pulse = (hold >= 6);
        for (int i = 1; i <= hold + 10; i++)
            push(k + i, K_EN, (run || (pulse && i == 7)) ? 32'd1 : 32'd0);
        step = 1'b1;
        wait_cyc(hold);
        step = 1'b0;
        wait_cyc(10);
    endtask

    task automatic do_addr(input int which);
        int k;
        int nxt;
        k   = cyc;
        nxt = model_next(addr_m, which, mode_m);
        push(k + 6, K_ADDR, 32'(addr_m));
        push(k + 7, K_ADDR, 32'(nxt));
        addr_m = nxt;
        inc    = (which == 1 || which == 3);
        dec    = (which == 2 || which == 3);
        wait_cyc(6);
        inc = 1'b0;
        dec = 1'b0;
        wait_cyc(10);
    endtask

    task automatic set_mode(input bit m);
        int k;
        k      = cyc;
        m_rf   = m;
        mode_m = m;
        addr_m = 0;
        push(k + 4, K_ADDR, 32'd0);
        wait_cyc(6);
    endtask

    task automatic show(input logic [2:0] s, input logic [1:0] ss,
                        input logic [31:0] md, input logic [31:0] rd,
                        input logic [31:0] od, input logic [15:0] st);
        int          k;
        logic [31:0] es;
        logic [15:0] el;
        k          = cyc;
        sel        = s;
        sub_sel    = ss;
        m_data     = md;
        rf_data    = rd;
        o_sel_data = od;
        status     = st;
        if (s == 3'd0) begin
            es = mode_m ? md : rd;
            el = {mode_m, 5'b0, 10'(addr_m)};
        end else begin
            es = od;
            el = st;
        end
        for (int d = 1; d <= 2; d++) begin
            push(k + d, K_SEG, es);
            push(k + d, K_LED, {16'b0, el});
            push(k + d, K_S0, {29'b0, s});
            push(k + d, K_S1, {30'b0, ss});
        end
        wait_cyc(3);
    endtask

    initial begin
        int k;
        int guard;

        wait_cyc(1);
        push_all_zero(cyc);
        push_all_zero(cyc + 1);
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(2);

        do_step(10, 1'b0);
        do_step(2, 1'b0);
        for (int i = 0; i < 3; i++) do_step($urandom_range(10, 6), 1'b0);

        k = cyc;
        succ = 1'b1;
        push(k + 1, K_EN, 32'd0);
        push(k + 2, K_EN, 32'd0);
        for (int i = 3; i <= 12; i++) push(k + i, K_EN, 32'd1);
        wait_cyc(12);
        do_step(6, 1'b1);
        do_step(8, 1'b1);
        k = cyc;
        succ = 1'b0;
        push(k + 1, K_EN, 32'd1);
        push(k + 2, K_EN, 32'd1);
        for (int i = 3; i <= 8; i++) push(k + i, K_EN, 32'd0);
        wait_cyc(8);

        for (int i = 0; i < 33; i++) do_addr(1);
        do_addr(2);
        do_addr(2);
        do_addr(3);
        for (int i = 0; i < 8; i++) do_addr($urandom_range(3, 1));
        show(3'd0, 2'd2, $urandom, $urandom, $urandom, 16'($urandom));

        set_mode(1'b1);
        do_addr(2);
        do_addr(1);
        for (int i = 0; i < 4; i++) do_addr(1);
        set_mode(1'b0);
        set_mode(1'b1);
        for (int i = 0; i < 8; i++) do_addr($urandom_range(3, 1));
        show(3'd0, 2'd0, 32'hDEADBEEF, 32'h0BADF00D, 32'd0, 16'd0);
        show(3'd3, 2'd1, 32'd0, 32'd0, 32'h12345678, 16'hA5A5);
        for (int i = 0; i < 8; i++)
            show(3'($urandom_range(7, 0)), 2'($urandom), $urandom,
                 $urandom, $urandom, 16'($urandom));

        sel = 3'd0;
        wait_cyc(2);
        k = cyc;
        step = 1'b1;
        wait_cyc(4);
        rst  = 1'b1;
        step = 1'b0;
        addr_m = 0;
        push_all_zero(cyc);
        push_all_zero(cyc + 1);
        push_all_zero(cyc + 2);
        wait_cyc(3);
        rst = 1'b0;
        for (int i = 0; i <= 14; i++) push(cyc + i, K_EN, 32'd0);
        wait_cyc(16);

        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            wait_cyc(1);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain left=%0d expected=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
